// File: rtl/pulse_capture_pkg.sv
// Shared types and constants for the pulse edge-timestamp capture block.
package pulse_capture_pkg;

   localparam int TS_W_DEF = 16;

   localparam logic TRIG_RISE = 1'b0;
   localparam logic TRIG_FALL = 1'b1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } cap_state_e;

   typedef struct packed {
      logic                level;
      logic [TS_W_DEF-1:0] ts;
   } cap_entry_t;

endpackage

// File: rtl/capture_fifo.sv
// Show-ahead synchronous FIFO holding captured {level, ts} entries; clr empties it.
module capture_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 17
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   input  logic                   push,
   input  logic [W-1:0]           push_data,
   input  logic                   pop,
   output logic [W-1:0]           head,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          full, do_push, do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full && !clr;
   assign do_pop  = pop && !empty && !clr;

   // Head is forced to zero when empty so the unreset storage never leaks out.
   assign head = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/pulse_capture.sv
// Arms on a selected edge of pulse_i, then timestamps every level transition into a buffer.
module pulse_capture
   import pulse_capture_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int TS_W  = 16
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_ni,
   input  logic                   pulse_i,
   input  logic                   arm_i,
   input  logic                   trig_edge_i,
   input  logic                   abort_i,
   input  logic                   rd_i,
   output logic [TS_W:0]          rd_data_o,
   output logic                   rd_valid_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic [1:0]             state_o,
   output logic                   done_o,
   output logic                   overflow_o
);

   localparam int CW = $clog2(DEPTH) + 1;

   cap_state_e    state_q, state_d;
   logic          p_q;
   logic [TS_W-1:0] ts_q, ts_d;
   logic [CW-1:0] capt_q, capt_d;
   logic          ovf_q, ovf_d;
   logic          edge_det, trig_hit, ts_max;
   logic          push, clr, fifo_empty;
   logic [TS_W:0] push_data;

   assign edge_det = (pulse_i != p_q);
   assign trig_hit = edge_det && ((trig_edge_i == TRIG_RISE) ? pulse_i : !pulse_i);
   assign ts_max   = &ts_q;

   always_comb begin
      state_d   = state_q;
      ts_d      = ts_q;
      capt_d    = capt_q;
      ovf_d     = ovf_q;
      push      = 1'b0;
      clr       = 1'b0;
      push_data = {pulse_i, ts_q};
      if (arm_i) begin
         clr     = 1'b1;
         ts_d    = '0;
         capt_d  = '0;
         ovf_d   = 1'b0;
         state_d = ARMED;
      end else if (abort_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            ARMED: if (trig_hit) begin
               push      = 1'b1;
               push_data = {pulse_i, {TS_W{1'b0}}};
               ts_d      = TS_W'(1);
               capt_d    = CW'(1);
               state_d   = CAPTURE;
            end
            CAPTURE: begin
               if (!ts_max) ts_d = ts_q + 1'b1;
               // An edge in the saturation cycle is still recorded; DONE waits for a quiet cycle.
               if (edge_det) begin
                  push   = 1'b1;
                  capt_d = capt_q + 1'b1;
                  if (capt_d == CW'(DEPTH)) state_d = DONE;
               end else if (ts_max) begin
                  state_d = DONE;
                  ovf_d   = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         state_q <= IDLE;
         p_q     <= 1'b0;
         ts_q    <= '0;
         capt_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         p_q     <= pulse_i;
         ts_q    <= ts_d;
         capt_q  <= capt_d;
         ovf_q   <= ovf_d;
      end
   end

   capture_fifo #(.DEPTH(DEPTH), .W(TS_W+1)) u_fifo (
      .clk       (wb_clk_i),
      .rst_n     (wb_rst_ni),
      .clr       (clr),
      .push      (push),
      .push_data (push_data),
      .pop       (rd_i),
      .head      (rd_data_o),
      .empty     (fifo_empty),
      .count     (count_o)
   );

   assign rd_valid_o = !fifo_empty;
   assign state_o    = state_q;
   assign done_o     = (state_q == DONE);
   assign overflow_o = ovf_q;

endmodule

// File: tb/tb_pulse_capture.sv
// Directed bench for pulse_capture: a TS_W=16 instance plus a TS_W=4 instance for saturation.
module tb_pulse_capture;

   logic clk = 1'b0;
   logic rst_n, pulse, arm, trig_edge, abort, rd;

   logic [16:0] rd_data;
   logic        rd_valid, done, ovf;
   logic [4:0]  count;
   logic [1:0]  state;

   logic [4:0]  rd_data4;
   logic        rd_valid4, done4, ovf4;
   logic [4:0]  count4;
   logic [1:0]  state4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pulse_capture #(.DEPTH(16), .TS_W(16)) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .pulse_i(pulse), .arm_i(arm),
      .trig_edge_i(trig_edge), .abort_i(abort), .rd_i(rd),
      .rd_data_o(rd_data), .rd_valid_o(rd_valid), .count_o(count),
      .state_o(state), .done_o(done), .overflow_o(ovf)
   );

   pulse_capture #(.DEPTH(16), .TS_W(4)) dut4 (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .pulse_i(pulse), .arm_i(arm),
      .trig_edge_i(trig_edge), .abort_i(abort), .rd_i(rd),
      .rd_data_o(rd_data4), .rd_valid_o(rd_valid4), .count_o(count4),
      .state_o(state4), .done_o(done4), .overflow_o(ovf4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_arm(input logic te);
      arm = 1'b1;
      trig_edge = te;
      tick();
      arm = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; pulse = 1'b0; arm = 1'b0; trig_edge = 1'b0; abort = 1'b0; rd = 1'b0;
      tick(2);
      chk("rst_state", 32'(state), 0);
      chk("rst_valid", 32'(rd_valid), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_ovf", 32'(ovf), 0);
      chk("rst_data", 32'(rd_data), 0);
      rst_n = 1'b1;
      tick();

      // high 5, low 3, high 5 after a rising trigger
      do_arm(1'b0);
      chk("t1_armed", 32'(state), 1);
      pulse = 1'b1; tick(5);
      pulse = 1'b0; tick(3);
      pulse = 1'b1; tick(5);
      chk("t1_count", 32'(count), 3);
      chk("t1_state", 32'(state), 2);
      chk("t1_e0", 32'(rd_data), 32'h10000);
      rd = 1'b1; tick(); rd = 1'b0;
      chk("t1_e1", 32'(rd_data), 32'h00005);
      chk("t1_cnt2", 32'(count), 2);
      rd = 1'b1; tick();
      chk("t1_e2", 32'(rd_data), 32'h10008);
      tick();
      chk("t1_empty", 32'(rd_valid), 0);
      tick();
      chk("t1_pop_empty", 32'(count), 0);
      rd = 1'b0;

      // 17 toggles every 2 cycles; only 16 stored
      pulse = 1'b0;
      do_arm(1'b0);
      for (int i = 0; i < 17; i++) begin
         pulse = ~pulse;
         tick(2);
      end
      chk("t2_done", 32'(done), 1);
      chk("t2_state", 32'(state), 3);
      chk("t2_count", 32'(count), 16);
      chk("t2_first", 32'(rd_data), 32'h10000);
      rd = 1'b1; tick(15); rd = 1'b0;
      chk("t2_last", 32'(rd_data), 32'h0001E);
      chk("t2_cnt1", 32'(count), 1);

      // timestamp saturation on the 4-bit instance
      pulse = 1'b0;
      do_arm(1'b0);
      pulse = 1'b1; tick();
      tick(14);
      chk("t3_still_capt", 32'(state4), 2);
      tick();
      chk("t3_state", 32'(state4), 3);
      chk("t3_done", 32'(done4), 1);
      chk("t3_ovf", 32'(ovf4), 1);
      chk("t3_count", 32'(count4), 1);
      chk("t3_data", 32'(rd_data4), 32'h10);
      chk("t3_wide_no_ovf", 32'(ovf), 0);

      // falling trigger; arm-cycle falling edge must be ignored
      pulse = 1'b0;
      do_arm(1'b1);
      chk("t3_ovf_clr", 32'(ovf4), 0);
      chk("t4_arm_edge_cnt", 32'(count), 0);
      chk("t4_arm_edge_st", 32'(state), 1);
      pulse = 1'b1; tick();
      chk("t4_rise_cnt", 32'(count), 0);
      chk("t4_rise_st", 32'(state), 1);
      pulse = 1'b0; tick();
      chk("t4_fall_cnt", 32'(count), 1);
      chk("t4_fall_st", 32'(state), 2);
      chk("t4_fall_vld", 32'(rd_valid), 1);
      chk("t4_fall_data", 32'(rd_data), 0);

      // push and pop every cycle
      for (int i = 1; i <= 6; i++) begin
         pulse = ~pulse;
         rd = 1'b1;
         tick();
         chk("t5_count", 32'(count), 1);
         chk("t5_data", 32'(rd_data), {15'd0, pulse, 16'(i)});
      end
      rd = 1'b0;

      // abort keeps data; arm outranks abort
      abort = 1'b1; tick(); abort = 1'b0;
      chk("t6_abort_st", 32'(state), 0);
      chk("t6_abort_cnt", 32'(count), 1);
      arm = 1'b1; abort = 1'b1; pulse = 1'b1; trig_edge = 1'b0;
      tick();
      arm = 1'b0; abort = 1'b0;
      chk("t6_arm_prio", 32'(state), 1);
      chk("t6_arm_edge", 32'(count), 0);
      pulse = 1'b0; tick();
      pulse = 1'b1; tick();
      chk("t6_capt", 32'(state), 2);
      tick(3);
      rst_n = 1'b0; tick();
      chk("t6_rst_state", 32'(state), 0);
      chk("t6_rst_count", 32'(count), 0);
      chk("t6_rst_valid", 32'(rd_valid), 0);
      chk("t6_rst_data", 32'(rd_data), 0);
      chk("t6_rst_done", 32'(done), 0);
      chk("t6_rst_ovf4", 32'(ovf4), 0);
      rst_n = 1'b1;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
